obi_mem_arbiter: RTL and testbench

// Arbitrates the core instruction port and data port onto one shared OBI-style memory port, e.g. a single-ported TB RAM.

---
 rtl/obi_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
//   Shares one OBI-style memory port between a core's instruction port and
//   its data port. Data has fixed priority. Instr wins once it has lost
//   STARVE_LIMIT consecutive cycles. A small owner FIFO remembers who owns
//   each granted-but-unanswered transaction, so in-order mem responses can
//   be steered back to the right requester.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   instr_*                 read-only request/response channel (req/addr/gnt/rvalid/rdata)
//   data_*                  read/write request/response channel
//   mem_*                   shared downstream port (req/addr/we/be/wdata -> gnt/rvalid/rdata)
//   err_o                   sticky flag: a mem response arrived with nothing outstanding
module obi_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i,
   output logic                  err_o
);

   typedef enum logic {SEL_INSTR = 1'b0, SEL_DATA = 1'b1} sel_e;

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
   localparam logic [PW-1:0] LAST  = PW'(MAX_OUTSTANDING - 1);

   logic          rst_q;       // keeps the port quiet for one cycle after reset
   logic          active;
   sel_e          owner_q [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [SW-1:0] starve_q;
   logic          lock_q;
   sel_e          lock_sel_q;
   logic          err_q;

   sel_e          sel;
   logic          full, empty, push, pop, spurious;

   always_comb begin
      active = !rst_i && !rst_q;
      full   = (cnt_q == DEPTH);
      empty  = (cnt_q == '0);

      // A request left ungranted is locked so the slave never sees it change.
      if (lock_q)                                sel = lock_sel_q;
      else if (starve_q == SLIM && instr_req_i)  sel = SEL_INSTR;
      else if (data_req_i)                       sel = SEL_DATA;
      else                                       sel = SEL_INSTR;

      // Full blocks even when a pop lands this cycle: the FIFO count is
      // registered, so the freed slot is usable only from the next cycle.
      mem_req_o   = active && !full && (lock_q || instr_req_i || data_req_i);
      push        = mem_req_o && mem_gnt_i;
      instr_gnt_o = push && (sel == SEL_INSTR);
      data_gnt_o  = push && (sel == SEL_DATA);

      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_wdata_o = '0;
      if (active) begin
         if (sel == SEL_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_addr_o  = instr_addr_i;
            mem_be_o    = 4'hF;
         end
      end

      pop            = active && mem_rvalid_i && !empty;
      // During the post-reset quiet cycle the FIFO is already empty, so a
      // late response from before reset still gets flagged.
      spurious       = !rst_i && mem_rvalid_i && empty;
      instr_rvalid_o = pop && (owner_q[rd_ptr_q] == SEL_INSTR);
      data_rvalid_o  = pop && (owner_q[rd_ptr_q] == SEL_DATA);
      instr_rdata_o  = active ? mem_rdata_i : '0;
      data_rdata_o   = active ? mem_rdata_i : '0;
      err_o          = err_q;
   end

   always_ff @(posedge clk_i) begin
      rst_q <= rst_i;
      if (rst_i || rst_q) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         starve_q   <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= SEL_INSTR;
      end else begin
         if (push) begin
            owner_q[wr_ptr_q] <= sel;
            wr_ptr_q          <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)
            cnt_q <= cnt_q + 1'b1;
         else if (pop && !push)
            cnt_q <= cnt_q - 1'b1;

         if (instr_req_i && !instr_gnt_o) begin
            if (starve_q != SLIM)
               starve_q <= starve_q + 1'b1;
         end else begin
            starve_q <= '0;
         end

         if (mem_req_o) begin
            lock_q     <= !mem_gnt_i;
            lock_sel_q <= sel;
         end
      end

      if (rst_i)
         err_q <= 1'b0;
      else if (spurious)
         err_q <= 1'b1;
   end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;
   localparam int AW   = 32;
   localparam int MAXO = 2;
   localparam int LIM  = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          instr_req_i, instr_gnt_o, instr_rvalid_o;
   logic [AW-1:0] instr_addr_i;
   logic [31:0]   instr_rdata_o;
   logic          data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
   logic [AW-1:0] data_addr_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_wdata_i, data_rdata_o;
   logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, err_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [31:0]   mem_wdata_o, mem_rdata_i;

   always #5 clk = ~clk;

   obi_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owners kept as a queue (1 = data), plain counters.
   bit          mq[$];
   int          m_starve;
   bit          m_lock, m_lsel, m_err, m_rstq;
   bit          e_req, e_igt, e_dgt, e_irv, e_drv, e_sel;
   logic [31:0] e_addr, e_wdata, e_rdata;
   logic        e_we;
   logic [3:0]  e_be;

   task automatic reset_model();
      mq.delete(); m_starve = 0; m_lock = 0; m_lsel = 0; m_err = 0; m_rstq = 0;
   endtask

   task automatic model_eval();
      bit act;
      act = !rst_i && !m_rstq;
      if (m_lock)                              e_sel = m_lsel;
      else if (m_starve >= LIM && instr_req_i) e_sel = 1'b0;
      else                                     e_sel = data_req_i;
      e_req   = act && (mq.size() < MAXO) && (m_lock || instr_req_i || data_req_i);
      e_igt   = e_req && mem_gnt_i && !e_sel;
      e_dgt   = e_req && mem_gnt_i && e_sel;
      e_irv   = act && mem_rvalid_i && mq.size() > 0 && mq[0] == 1'b0;
      e_drv   = act && mem_rvalid_i && mq.size() > 0 && mq[0] == 1'b1;
      e_addr  = e_sel ? data_addr_i : instr_addr_i;
      e_we    = e_sel ? data_we_i : 1'b0;
      e_be    = e_sel ? data_be_i : 4'hF;
      e_wdata = e_sel ? data_wdata_i : 32'h0;
      e_rdata = act ? mem_rdata_i : 32'h0;
   endtask

   task automatic model_step();
      if (rst_i) begin
         mq.delete(); m_starve = 0; m_lock = 0; m_err = 0;
      end else if (m_rstq) begin
         if (mem_rvalid_i) m_err = 1;
      end else begin
         if (mem_rvalid_i) begin
            if (mq.size() == 0) m_err = 1;
            else void'(mq.pop_front());
         end
         if (e_igt || e_dgt) mq.push_back(e_sel);
         m_starve = (instr_req_i && !e_igt) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
         if (e_req) begin m_lock = !mem_gnt_i; m_lsel = e_sel; end
      end
      m_rstq = rst_i;
   endtask

   task automatic clear_inputs();
      instr_req_i = 0; instr_addr_i = '0;
      data_req_i = 0; data_addr_i = '0; data_we_i = 0; data_be_i = 4'h0; data_wdata_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      clear_inputs(); rst_i = 1;
      repeat (2) tick();
      rst_i = 0;
      tick();
   endtask

   task automatic test_reset();
      rst_i = 1;
      for (int c = 0; c < 3; c++) begin
         instr_req_i = $urandom; instr_addr_i = $urandom;
         data_req_i = $urandom; data_addr_i = $urandom; data_we_i = $urandom;
         data_be_i = $urandom; data_wdata_i = $urandom;
         mem_gnt_i = 1; mem_rvalid_i = $urandom; mem_rdata_i = $urandom;
         @(negedge clk);
         n_checks++;
         if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o, mem_we_o} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o, mem_we_o});
         end
         n_checks++;
         if ({mem_addr_o, mem_be_o, mem_wdata_o, instr_rdata_o, data_rdata_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h be %h wdata %h rdata %h/%h expected all 0", mem_addr_o, mem_be_o, mem_wdata_o, instr_rdata_o, data_rdata_o);
         end
         tick();
      end
      rst_i = 0; clear_inputs();
      data_req_i = 1; data_addr_i = 32'h40; mem_gnt_i = 1;
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, data_gnt_o, err_o} !== 3'b000) begin
         n_fail++; $display("FAIL reset_quiet_cycle: req/gnt/err %b expected 000", {mem_req_o, data_gnt_o, err_o});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, data_gnt_o, err_o} !== 3'b110 || mem_addr_o !== 32'h40) begin
         n_fail++; $display("FAIL reset_first_req: req/gnt/err %b addr %h expected 110 addr 40", {mem_req_o, data_gnt_o, err_o}, mem_addr_o);
      end
      tick();
   endtask

   task automatic test_priority();
      apply_reset();
      instr_req_i = 1; instr_addr_i = 32'h200; data_req_i = 1; data_addr_i = 32'h100; mem_gnt_i = 1;
      @(negedge clk);
      n_checks++;
      if ({data_gnt_o, instr_gnt_o} !== 2'b10 || mem_addr_o !== 32'h100) begin
         n_fail++; $display("FAIL prio_data_first: dgnt/ignt %b addr %h expected 10 addr 100", {data_gnt_o, instr_gnt_o}, mem_addr_o);
      end
      tick();
      data_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if ({data_rvalid_o, instr_rvalid_o} !== 2'b10 || data_rdata_o !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL prio_data_resp: drv/irv %b rdata %h expected 10 deadbeef", {data_rvalid_o, instr_rvalid_o}, data_rdata_o);
      end
      n_checks++;
      if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_be_o !== 4'hF || mem_we_o !== 1'b0) begin
         n_fail++; $display("FAIL prio_instr_next: ignt %b addr %h be %h we %b expected 1 200 f 0", instr_gnt_o, mem_addr_o, mem_be_o, mem_we_o);
      end
      tick();
      instr_req_i = 0; mem_rdata_i = 32'h1234;
      @(negedge clk);
      n_checks++;
      if ({data_rvalid_o, instr_rvalid_o} !== 2'b01 || instr_rdata_o !== 32'h1234) begin
         n_fail++; $display("FAIL prio_instr_resp: drv/irv %b rdata %h expected 01 1234", {data_rvalid_o, instr_rvalid_o}, instr_rdata_o);
      end
      tick();
   endtask

   task automatic test_starvation();
      apply_reset();
      instr_req_i = 1; instr_addr_i = 32'h800; data_req_i = 1; data_addr_i = 32'h400; mem_gnt_i = 1;
      for (int c = 1; c <= 10; c++) begin
         mem_rvalid_i = (c > 1);
         @(negedge clk);
         n_checks++;
         if ({instr_gnt_o, data_gnt_o} !== ((c % 5 == 0) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL starve_gnt c%0d: ignt/dgnt %b expected %b", c, {instr_gnt_o, data_gnt_o}, (c % 5 == 0) ? 2'b10 : 2'b01);
         end
         if (c > 1) begin
            n_checks++;
            if ({instr_rvalid_o, data_rvalid_o} !== (((c - 1) % 5 == 0) ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL starve_route c%0d: irv/drv %b", c, {instr_rvalid_o, data_rvalid_o});
            end
         end
         tick();
      end
   endtask

   task automatic test_lock();
      apply_reset();
      instr_req_i = 1; instr_addr_i = 32'h300;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) begin data_req_i = 1; data_addr_i = 32'h104; end
         mem_gnt_i = (c == 3);
         @(negedge clk);
         n_checks++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300 || data_gnt_o !== 1'b0 || instr_gnt_o !== (c == 3)) begin
            n_fail++; $display("FAIL lock_hold c%0d: req %b addr %h ignt %b dgnt %b expected addr 300", c, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o);
         end
         tick();
      end
      instr_req_i = 0;
      @(negedge clk);
      n_checks++;
      if (data_gnt_o !== 1'b1 || mem_addr_o !== 32'h104) begin
         n_fail++; $display("FAIL lock_release: dgnt %b addr %h expected 1 104", data_gnt_o, mem_addr_o);
      end
      tick();
   endtask

   task automatic test_full();
      apply_reset();
      data_req_i = 1; data_addr_i = 32'h10; mem_gnt_i = 1;
      for (int c = 1; c <= 5; c++) begin
         if (c == 2) data_addr_i = 32'h14;
         if (c == 3) begin instr_req_i = 1; instr_addr_i = 32'h500; data_addr_i = 32'h18; end
         mem_rvalid_i = (c == 4);
         @(negedge clk);
         n_checks++;
         if ({mem_req_o, data_gnt_o, instr_gnt_o} !== ((c == 3 || c == 4) ? 3'b000 : 3'b110)) begin
            n_fail++; $display("FAIL full c%0d: req/dgnt/ignt %b", c, {mem_req_o, data_gnt_o, instr_gnt_o});
         end
         if (c == 4) begin
            n_checks++;
            if (data_rvalid_o !== 1'b1) begin
               n_fail++; $display("FAIL full_pop: drv %b expected 1", data_rvalid_o);
            end
         end
         tick();
      end
   endtask

   task automatic test_spurious();
      apply_reset();
      mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
      @(negedge clk);
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b000) begin
         n_fail++; $display("FAIL spur_no_rvalid: irv/drv/err %b expected 000", {instr_rvalid_o, data_rvalid_o, err_o});
      end
      tick();
      mem_rvalid_i = 0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (err_o !== 1'b1) begin
            n_fail++; $display("FAIL spur_err_sticky: err %b expected 1", err_o);
         end
         tick();
      end
   endtask

   task automatic test_random();
      bit gi = 0, gd = 0;
      apply_reset(); reset_model();
      for (int c = 0; c < 3000; c++) begin
         rst_i = ($urandom_range(0, 299) == 0);
         if (!instr_req_i || gi) begin
            instr_req_i = ($urandom_range(0, 2) != 0); instr_addr_i = $urandom;
         end
         if (!data_req_i || gd) begin
            data_req_i = $urandom; data_addr_i = $urandom; data_we_i = $urandom;
            data_be_i = $urandom; data_wdata_i = $urandom;
         end
         mem_gnt_i    = ($urandom_range(0, 3) != 0);
         mem_rvalid_i = (mq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 299) == 0);
         mem_rdata_i  = $urandom;
         model_eval();
         @(negedge clk);
         n_checks++;
         if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o} !== {e_req, e_igt, e_dgt, e_irv, e_drv, m_err}) begin
            n_fail++; $display("FAIL rand_ctrl c%0d: req/ig/dg/irv/drv/err %b expected %b", c,
               {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o}, {e_req, e_igt, e_dgt, e_irv, e_drv, m_err});
         end
         if (e_req) begin
            n_checks++;
            if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {e_addr, e_we, e_be, e_wdata}) begin
               n_fail++; $display("FAIL rand_fields c%0d: %h %b %h %h expected %h %b %h %h", c,
                  mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, e_addr, e_we, e_be, e_wdata);
            end
         end
         n_checks++;
         if ({instr_rdata_o, data_rdata_o} !== {e_rdata, e_rdata}) begin
            n_fail++; $display("FAIL rand_rdata c%0d: %h/%h expected %h", c, instr_rdata_o, data_rdata_o, e_rdata);
         end
         gi = e_igt; gd = e_dgt;
         @(posedge clk);
         model_step();
         #1;
      end
      clear_inputs(); rst_i = 0;
   endtask

   initial begin
      rst_i = 1;
      clear_inputs();
      test_reset();
      test_priority();
      test_starvation();
      test_lock();
      test_full();
      test_spurious();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
